i8088_bus_master: RTL and testbench
===================================

Name: i8088_bus_master

Overview:
- Synthesizable 8088 minimum-mode bus-cycle generator.
- Converts a valid/ready command stream (mem/IO, read/write) into T1-T2-T3-[TW]-T4 cycles on the multiplexed 8088 pins: AD7..0, A19..8, ALE, nRD, nWR, IO/nM, DT/nR, nDEN, READY.
- Next generation of the hand-sequenced CPU stimulus: parametrised T-state timing, wait states, bus-hang timeout, back-to-back cycles.
- Used in simulation benches against jisaku_pc_top and as an on-FPGA bus self-test master.

Parameters:
- ADDR_W, 20: bus address width (17..20); upper bits drive addr_hi.
- TCLK_DIV, 4: clk cycles per T-state (>=2).
- READY_SYNC, 2: synchroniser flops on the ready input (>=1).
- TIMEOUT, 1024: maximum TW states before the cycle is aborted.
- IDLE_TI, 1: idle Ti states inserted between bus cycles (>=0).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_io  in  1  1=IO cycle, 0=memory cycle
- cmd_addr  in  ADDR_W  bus address
- cmd_wdata  in  8  write data
- rsp_valid  out  1  one-clock completion pulse
- rsp_rdata  out  8  read data (0xFF on timeout or write)
- rsp_timeout  out  1  qualifies rsp_valid; cycle aborted
- ale  out  1  address latch enable
- nrd, nwr  out  1 each  strobes, active low
- io_nm  out  1  IO/nM
- dt_nr  out  1  DT/nR
- nden  out  1  data enable, active low
- addr_hi  out  ADDR_W-8  A[ADDR_W-1:8]
- ad_out  out  8  AD7..0 drive value
- ad_oe  out  1  AD7..0 output enable
- ad_in  in  8  AD7..0 sampled value
- ready  in  1  asynchronous READY from target

Behaviour:
- Reset values: cmd_ready=0, rsp_valid=0, rsp_rdata=0xFF, rsp_timeout=0, ale=0, nrd=1, nwr=1, io_nm=0, dt_nr=0, nden=1, addr_hi=0, ad_out=0, ad_oe=0. Reset also clears state, T-counter, wait counter and sync flops.
- Reset mid-cycle aborts immediately to reset values; no rsp_valid is issued.
- States: IDLE, TI, T1, T2, T3, TW, T4. Every state except IDLE lasts exactly TCLK_DIV clocks.
- IDLE: cmd_ready=1. On accept, latch the command; T1 starts on the next clock. cmd_ready=0 in all other states.
- T1: ale=1; addr_hi=addr[ADDR_W-1:8]; ad_out=addr[7:0]; ad_oe=1; io_nm=cmd_io and dt_nr=cmd_write, both held through T4.
- T2: ale=0; nden=0. Read: nrd=0, ad_oe=0. Write: nwr=0, ad_out=wdata, ad_oe=1.
- T3 and TW: strobes held. On the last clock of the state, sample rdy_s, the READY_SYNC-stage synchronised ready:
  - rdy_s=1: latch ad_in (read) and go to T4.
  - rdy_s=0 and wait count < TIMEOUT: go to TW and increment the wait count.
  - rdy_s=0 and wait count == TIMEOUT: set the timeout flag and go to T4.
- T4: nrd=nwr=1, nden=1, ad_oe=0 from its first clock.
- Completion, on the clock after T4 ends:
  - rsp_valid=1 for one clock.
  - rsp_rdata = latched data for a successful read, else 0xFF.
  - rsp_timeout = timeout flag.
  - Next state: TI when IDLE_TI>0, else IDLE.
- TI lasts IDLE_TI T-states with all strobes inactive, then IDLE.
- Cycle length with no waits: 4*TCLK_DIV clocks from T1 start to rsp_valid. Each TW adds TCLK_DIV.
- Back-to-back with IDLE_TI=0: cmd_ready rises with rsp_valid; the next T1 starts one clock after accept.
- The wait counter is wide enough for TIMEOUT and does not wrap.
- ready glitches outside T3/TW are ignored.

Decomposition:
- Package i8088_bus_pkg: state enum (IDLE, TI, T1, T2, T3, TW, T4); cmd struct {write, io, addr, wdata}; constant RDATA_ABORT=8'hFF.
- Sub-module i8088_ready_sync: parametrised READY_SYNC-stage synchroniser with synchronous reset to 0.

Test Plan:
- Mem write 0x20000 data 0x09, ready tied 1, TCLK_DIV=4 -> ale high for 4 clk; nwr low for 8 clk; ad_out=0x09 during T2/T3; io_nm=0; dt_nr=1; rsp_valid 16 clk after T1 start, rsp_timeout=0.
- Mem read 0x20000, target holds ready low for 3 TW then drives 0x5A -> cycle is 7 T-states (28 clk); rsp_rdata=0x5A; nrd low T2..TW end.
- IO write addr 0x00080 data 0x03 -> io_nm=1 T1..T4; addr_hi=0x000; ad_out=0x80 in T1, 0x03 in T2.
- Read with ready stuck 0, TIMEOUT=8 -> exactly 8 TW; rsp_timeout=1; rsp_rdata=0xFF; returns to IDLE.
- Two queued commands, IDLE_TI=0 -> second T1 starts 1 clk after first rsp_valid. With IDLE_TI=1 -> 4 extra clk of idle gap.
- rst asserted during TW -> next clock all outputs at reset values, no rsp_valid; a new command after release completes normally.

Source files
------------

// File: rtl/i8088_bus_pkg.sv
// Shared types for the 8088 minimum-mode bus master.
//   bus_state_t : T-state sequencer encoding (IDLE, TI, T1, T2, T3, TW, T4)
//   bus_cmd_t   : latched command {write, io, addr, wdata}; addr is sized for
//                 the widest bus (20 bits) and narrower buses use the low bits
//   RDATA_ABORT : read data returned for writes and timed-out cycles
package i8088_bus_pkg;

  localparam int unsigned BUS_ADDR_MAX = 20;

  localparam logic [7:0] RDATA_ABORT = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TI,
    S_T1,
    S_T2,
    S_T3,
    S_TW,
    S_T4
  } bus_state_t;

  typedef struct packed {
    logic                    write;
    logic                    io;
    logic [BUS_ADDR_MAX-1:0] addr;
    logic [7:0]              wdata;
  } bus_cmd_t;

endpackage

// File: rtl/i8088_ready_sync.sv
// Multi-flop synchroniser for the asynchronous READY input.
//   clk   : system clock
//   rst   : synchronous active-high reset, clears every stage to 0
//   ready : asynchronous READY from the bus target
//   rdy_s : READY after STAGES flops
module i8088_ready_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ready,
  output logic rdy_s
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= ready;
      for (int unsigned i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign rdy_s = sync_q[STAGES-1];

endmodule

// File: rtl/i8088_bus_master.sv
// 8088 minimum-mode bus-cycle generator.
// Turns a valid/ready command stream into T1-T2-T3-[TW]-T4 bus cycles on the
// multiplexed 8088 pins and returns a one-clock completion pulse.
//   clk, rst                        : clock, synchronous active-high reset
//   cmd_valid/cmd_ready             : command handshake
//   cmd_write, cmd_io, cmd_addr,
//   cmd_wdata                       : command fields
//   rsp_valid, rsp_rdata,
//   rsp_timeout                     : completion pulse, read data, abort flag
//   ale, nrd, nwr, io_nm, dt_nr,
//   nden, addr_hi, ad_out, ad_oe    : 8088 bus pins (AD7..0 split in/out/oe)
//   ad_in                           : sampled AD7..0
//   ready                           : asynchronous READY from the target
module i8088_bus_master
  import i8088_bus_pkg::*;
#(
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned TCLK_DIV   = 4,
  parameter int unsigned READY_SYNC = 2,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned IDLE_TI    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic              cmd_io,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_wdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic              rsp_timeout,
  output logic              ale,
  output logic              nrd,
  output logic              nwr,
  output logic              io_nm,
  output logic              dt_nr,
  output logic              nden,
  output logic [ADDR_W-9:0] addr_hi,
  output logic [7:0]        ad_out,
  output logic              ad_oe,
  input  logic [7:0]        ad_in,
  input  logic              ready
);

  localparam int unsigned TC_W = (TCLK_DIV > 1) ? $clog2(TCLK_DIV) : 1;
  localparam int unsigned WC_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TI_W = (IDLE_TI > 1) ? $clog2(IDLE_TI) : 1;

  localparam logic [TC_W-1:0] TC_LAST = TC_W'(TCLK_DIV - 1);
  localparam logic [WC_W-1:0] WC_MAX  = WC_W'(TIMEOUT);
  localparam logic [TI_W-1:0] TI_LAST = TI_W'((IDLE_TI > 0) ? IDLE_TI - 1 : 0);

  bus_state_t       state_q, state_d;
  logic [TC_W-1:0]  tcnt_q, tcnt_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic [TI_W-1:0]  ticnt_q, ticnt_d;
  bus_cmd_t         cmd_q, cmd_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             tmo_q, tmo_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_rdata_q, rsp_rdata_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic             rdy_s;
  logic             tlast;

  i8088_ready_sync #(
    .STAGES (READY_SYNC)
  ) u_ready_sync (
    .clk   (clk),
    .rst   (rst),
    .ready (ready),
    .rdy_s (rdy_s)
  );

  assign tlast = (tcnt_q == TC_LAST);

  // Sequencer. The T-counter free-runs inside every non-IDLE state and wraps
  // on the last clock, so repeated TW states need no extra bookkeeping.
  always_comb begin
    state_d       = state_q;
    tcnt_d        = (state_q == S_IDLE || tlast) ? '0 : tcnt_q + 1'b1;
    wcnt_d        = wcnt_q;
    ticnt_d       = ticnt_q;
    cmd_d         = cmd_q;
    rdata_d       = rdata_q;
    tmo_d         = tmo_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_d.write = cmd_write;
          cmd_d.io    = cmd_io;
          cmd_d.addr  = BUS_ADDR_MAX'(cmd_addr);
          cmd_d.wdata = cmd_wdata;
          wcnt_d      = '0;
          tmo_d       = 1'b0;
          state_d     = S_T1;
        end
      end
      S_TI: begin
        if (tlast) begin
          if (ticnt_q == TI_LAST) begin
            ticnt_d = '0;
            state_d = S_IDLE;
          end else begin
            ticnt_d = ticnt_q + 1'b1;
          end
        end
      end
      S_T1: if (tlast) state_d = S_T2;
      S_T2: if (tlast) state_d = S_T3;
      S_T3, S_TW: begin
        if (tlast) begin
          if (rdy_s) begin
            if (!cmd_q.write) rdata_d = ad_in;
            state_d = S_T4;
          end else if (wcnt_q < WC_MAX) begin
            wcnt_d  = wcnt_q + 1'b1;
            state_d = S_TW;
          end else begin
            tmo_d   = 1'b1;
            state_d = S_T4;
          end
        end
      end
      S_T4: begin
        if (tlast) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = (!cmd_q.write && !tmo_q) ? rdata_q : RDATA_ABORT;
          rsp_timeout_d = tmo_q;
          state_d       = (IDLE_TI > 0) ? S_TI : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Registered so it rises together with rsp_valid and stays low in reset.
    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      tcnt_q        <= '0;
      wcnt_q        <= '0;
      ticnt_q       <= '0;
      cmd_q         <= '0;
      rdata_q       <= '0;
      tmo_q         <= 1'b0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= RDATA_ABORT;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tcnt_q        <= tcnt_d;
      wcnt_q        <= wcnt_d;
      ticnt_q       <= ticnt_d;
      cmd_q         <= cmd_d;
      rdata_q       <= rdata_d;
      tmo_q         <= tmo_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Bus pins are a pure function of the current T-state and latched command.
  always_comb begin
    ale     = 1'b0;
    nrd     = 1'b1;
    nwr     = 1'b1;
    io_nm   = 1'b0;
    dt_nr   = 1'b0;
    nden    = 1'b1;
    addr_hi = '0;
    ad_out  = '0;
    ad_oe   = 1'b0;

    case (state_q)
      S_T1: begin
        ale     = 1'b1;
        io_nm   = cmd_q.io;
        dt_nr   = cmd_q.write;
        addr_hi = cmd_q.addr[ADDR_W-1:8];
        ad_out  = cmd_q.addr[7:0];
        ad_oe   = 1'b1;
      end
      S_T2, S_T3, S_TW: begin
        io_nm   = cmd_q.io;
        dt_nr   = cmd_q.write;
        addr_hi = cmd_q.addr[ADDR_W-1:8];
        nden    = 1'b0;
        if (cmd_q.write) begin
          nwr    = 1'b0;
          ad_out = cmd_q.wdata;
          ad_oe  = 1'b1;
        end else begin
          nrd    = 1'b0;
        end
      end
      S_T4: begin
        io_nm   = cmd_q.io;
        dt_nr   = cmd_q.write;
        addr_hi = cmd_q.addr[ADDR_W-1:8];
      end
      default: ;
    endcase
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_i8088_bus_master.sv
// Self-checking bench for i8088_bus_master. A behavioural target model drives
// READY/AD7..0 and predicts each cycle's T-state budget, pin activity and
// response from the bus-cycle rules, under directed and random commands.
module tb_i8088_bus_master;

  localparam int unsigned AW  = 20;
  localparam int unsigned D   = 4;   // clk per T-state
  localparam int unsigned N   = 2;   // READY synchroniser depth
  localparam int unsigned TMO = 8;   // maximum TW states
  localparam int unsigned ITI = 1;   // idle Ti states between cycles

  localparam logic [63:0] RESET_VEC = {26'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0,
                                       1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 12'h000,
                                       8'h00, 1'b0};

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write, cmd_io;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_wdata;
  logic          rsp_valid, rsp_timeout;
  logic [7:0]    rsp_rdata;
  logic          ale, nrd, nwr, io_nm, dt_nr, nden, ad_oe, ready;
  logic [AW-9:0] addr_hi;
  logic [7:0]    ad_out, ad_in;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned rsp_pulses   = 0;
  int unsigned rsp_expected = 0;
  int unsigned last_rsp_cyc = 0;

  i8088_bus_master #(
    .ADDR_W     (AW),
    .TCLK_DIV   (D),
    .READY_SYNC (N),
    .TIMEOUT    (TMO),
    .IDLE_TI    (ITI)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_io      (cmd_io),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_timeout (rsp_timeout),
    .ale         (ale),
    .nrd         (nrd),
    .nwr         (nwr),
    .io_nm       (io_nm),
    .dt_nr       (dt_nr),
    .nden        (nden),
    .addr_hi     (addr_hi),
    .ad_out      (ad_out),
    .ad_oe       (ad_oe),
    .ad_in       (ad_in),
    .ready       (ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rsp_valid === 1'b1) rsp_pulses <= rsp_pulses + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return {26'b0, cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, ale, nrd, nwr,
            io_nm, dt_nr, nden, addr_hi, ad_out, ad_oe};
  endfunction

  // One bus cycle, entered and left on a negedge. waits = TW states the target
  // asks for; stuck = READY never returns; b2b = issued right after a response;
  // abort_at = clock (from T1 start) at which rst is pulsed, 0 for none.
  task automatic bus_cycle(input logic wr, input logic io, input logic [AW-1:0] addr,
                           input logic [7:0] wd, input logic [7:0] rd,
                           input int unsigned waits, input logic stuck,
                           input logic b2b, input int unsigned abort_at);
    int unsigned w_exp = stuck ? TMO : waits;
    int unsigned len   = (4 + w_exp) * D;
    int unsigned rise  = (waits == 0) ? D : (waits + 3) * D - N - D / 2;
    int unsigned t1, k, guard;
    int unsigned ale_n = 0, strb_n = 0, other_n = 0, nden_n = 0, oe_n = 0;
    int unsigned iodt_bad = 0, wd_bad = 0;
    logic got_rsp = 1'b0;

    cmd_valid = 1'b1; cmd_write = wr; cmd_io = io; cmd_addr = addr; cmd_wdata = wd;
    ready = 1'b1;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    check("cmd_accept", cmd_ready, 1);
    if (cmd_ready !== 1'b1) begin
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    t1 = cyc;
    if (b2b) check("cycle_gap", t1 - last_rsp_cyc, 1 + ITI * D);

    k = 0;
    while (k <= (5 + TMO) * D) begin
      if (abort_at != 0 && k == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        check("abort_reset_vec", out_vec(), RESET_VEC);
        @(negedge clk);
        rst = 1'b0;
        ready = 1'b1;
        return;
      end
      if (rsp_valid === 1'b1) begin
        got_rsp = 1'b1;
        break;
      end
      if (ale) ale_n++;
      if (!nden) nden_n++;
      if (ad_oe) oe_n++;
      if (wr ? !nwr : !nrd) strb_n++;
      if (wr ? !nrd : !nwr) other_n++;
      if (k < len && (io_nm !== io || dt_nr !== wr)) iodt_bad++;
      if (wr && k >= D && k < (3 + w_exp) * D && ad_out !== wd) wd_bad++;
      if (k == 0) begin
        check("t1_addr_lo", {ad_oe, ad_out}, {1'b1, addr[7:0]});
        check("t1_addr_hi", addr_hi, addr[AW-1:8]);
      end
      if (k == D) check("t2_ad_oe", ad_oe, wr);
      // target model: READY noise during T1, then low until the rise point
      if (k < D) begin
        ready = 1'($urandom);
        ad_in = 8'($urandom);
      end else if (!stuck && k >= rise) begin
        ready = 1'b1;
        ad_in = rd;
      end else begin
        ready = 1'b0;
        ad_in = 8'($urandom);
      end
      @(negedge clk);
      k++;
    end
    ready = 1'b1;

    check("rsp_seen", got_rsp, 1);
    if (got_rsp) begin
      rsp_expected++;
      last_rsp_cyc = cyc;
      check("latency", cyc - t1, len);
      check("rsp_rdata", rsp_rdata, (wr || stuck) ? 8'hFF : rd);
      check("rsp_timeout", rsp_timeout, stuck);
    end
    check("ale_clks", ale_n, D);
    check("strobe_clks", strb_n, (2 + w_exp) * D);
    check("wrong_strobe_clks", other_n, 0);
    check("nden_clks", nden_n, (2 + w_exp) * D);
    check("ad_oe_clks", oe_n, wr ? (3 + w_exp) * D : D);
    check("io_dt_bad_clks", iodt_bad, 0);
    if (wr) check("wdata_bad_clks", wd_bad, 0);
  endtask

  initial begin
    logic          wr, io, stuck, b2b;
    logic [AW-1:0] addr;
    logic [7:0]    wd, rd;
    int unsigned   waits;

    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_io = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; ad_in = '0; ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_vec", out_vec(), RESET_VEC);
    rst = 1'b0;
    @(negedge clk);

    bus_cycle(1'b1, 1'b0, 20'h20000, 8'h09, 8'h00, 0, 1'b0, 1'b0, 0);
    bus_cycle(1'b0, 1'b0, 20'h20000, 8'h00, 8'h5A, 3, 1'b0, 1'b0, 0);
    bus_cycle(1'b1, 1'b1, 20'h00080, 8'h03, 8'h00, 0, 1'b0, 1'b0, 0);
    bus_cycle(1'b0, 1'b0, 20'h12345, 8'h00, 8'hC3, 0, 1'b1, 1'b0, 0);
    bus_cycle(1'b0, 1'b1, 20'h00060, 8'h00, 8'h11, 0, 1'b0, 1'b0, 0);
    bus_cycle(1'b1, 1'b0, 20'hFFFFF, 8'hA5, 8'h00, 1, 1'b0, 1'b1, 0);
    bus_cycle(1'b0, 1'b0, 20'hABCDE, 8'h00, 8'h77, 0, 1'b1, 1'b0, 4 * D + 1);
    bus_cycle(1'b0, 1'b0, 20'hABCDE, 8'h00, 8'h77, 1, 1'b0, 1'b0, 0);

    for (int i = 0; i < 20; i++) begin
      wr    = 1'($urandom);
      io    = 1'($urandom);
      addr  = AW'($urandom);
      wd    = 8'($urandom);
      rd    = 8'($urandom);
      waits = $urandom_range(0, 4);
      stuck = ($urandom_range(0, 7) == 0);
      b2b   = 1'($urandom);
      if (!b2b) repeat ($urandom_range(0, 5)) @(negedge clk);
      bus_cycle(wr, io, addr, wd, rd, waits, stuck, b2b, 0);
    end

    repeat (2 * D) @(negedge clk);
    check("rsp_pulse_total", rsp_pulses, rsp_expected);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
